// File: rtl/regfile_write_arbiter_if.sv
// Writeback, multdiv, decode-hazard and register-file write signals of regfile_write_arbiter.
// The master drives the requests; the slave (the arbiter) returns the grant, hazard and write-port signals.
interface regfile_write_arbiter_if #(
   parameter int DEPTH = 2
);
   logic                   pipe_we;
   logic [4:0]             pipe_reg;
   logic [31:0]            pipe_data;
   logic                   md_valid;
   logic [4:0]             md_reg;
   logic [31:0]            md_data;
   logic                   md_exception;
   logic                   md_ready;
   logic [4:0]             rs_a;
   logic [4:0]             rs_b;
   logic                   pend_hit;
   logic                   stall;
   logic                   rf_we;
   logic [4:0]             rf_reg;
   logic [31:0]            rf_data;
   logic [$clog2(DEPTH):0] pend_count;

   modport master (
      output pipe_we, pipe_reg, pipe_data, md_valid, md_reg, md_data, md_exception, rs_a, rs_b,
      input  md_ready, pend_hit, stall, rf_we, rf_reg, rf_data, pend_count
   );

   modport slave (
      input  pipe_we, pipe_reg, pipe_data, md_valid, md_reg, md_data, md_exception, rs_a, rs_b,
      output md_ready, pend_hit, stall, rf_we, rf_reg, rf_data, pend_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a multdiv result FIFO (writes from N+1).
// md_ready drops while the FIFO is full; a full FIFO (or, with ARB_STARVE_EN, an aged head) steals a slot and stalls writeback.
module regfile_write_arbiter #(
   parameter int          DEPTH        = 2,
   parameter int          STARVE_LIMIT = 4,
   parameter logic [4:0]  STATUS_REG   = 5'd30,
   parameter logic [31:0] MD_EXC_CODE  = 32'd4
) (
   input logic                    clock,
   input logic                    reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    fifo_reg  [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          nonempty;
   logic          ready;
   logic          pipe_live;
   logic          push;
   logic          store;
   logic          pop;
   logic          force_drain;
   logic [4:0]    push_reg;
   logic [31:0]   push_data;

   assign nonempty  = (count != '0);
   assign ready     = (count < CW'(DEPTH));
   assign pipe_live = bus.pipe_we && (bus.pipe_reg != 5'd0);
   assign push      = bus.md_valid && ready && !reset;
   // A $r0 result is consumed but never occupies a slot; exceptions always do.
   assign store     = push && (bus.md_exception || (bus.md_reg != 5'd0));
   assign push_reg  = bus.md_exception ? STATUS_REG  : bus.md_reg;
   assign push_data = bus.md_exception ? MD_EXC_CODE : bus.md_data;

   assign bus.md_ready   = ready && !reset;
   assign bus.pend_count = reset ? '0 : count;

`ifdef ARB_STARVE_EN
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   logic [AW-1:0] age;

   always_ff @(posedge clock) begin
      if (reset) begin
         age <= '0;
      end else if (pop || !nonempty) begin
         age <= '0;
      end else if (age != AW'(STARVE_LIMIT)) begin
         age <= age + AW'(1);
      end
   end

   assign force_drain = (count == CW'(DEPTH)) || (age == AW'(STARVE_LIMIT));
`else
   assign force_drain = (count == CW'(DEPTH));
`endif

   always_comb begin
      bus.rf_we   = 1'b0;
      bus.rf_reg  = '0;
      bus.rf_data = '0;
      bus.stall   = 1'b0;
      pop         = 1'b0;
      if (!reset) begin
         if (nonempty && force_drain) begin
            bus.rf_we   = 1'b1;
            bus.rf_reg  = fifo_reg[head];
            bus.rf_data = fifo_data[head];
            bus.stall   = pipe_live;
            pop         = 1'b1;
         end else if (pipe_live) begin
            bus.rf_we   = 1'b1;
            bus.rf_reg  = bus.pipe_reg;
            bus.rf_data = bus.pipe_data;
         end else if (nonempty) begin
            bus.rf_we   = 1'b1;
            bus.rf_reg  = fifo_reg[head];
            bus.rf_data = fifo_data[head];
            pop         = 1'b1;
         end
      end
   end

   // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
   always_comb begin
      logic [PW-1:0] offs;
      bus.pend_hit = 1'b0;
      offs         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - head;
         if (!reset && ({1'b0, offs} < count)) begin
            if (((fifo_reg[i] == bus.rs_a) && (bus.rs_a != 5'd0)) ||
                ((fifo_reg[i] == bus.rs_b) && (bus.rs_b != 5'd0))) begin
               bus.pend_hit = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (store) begin
         fifo_reg[tail]  <= push_reg;
         fifo_data[tail] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (store) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         case ({store, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a queue-based reference model.
// Optional starve scenario runs when ARB_STARVE_EN is defined.
module tb_regfile_write_arbiter;
   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

   regfile_write_arbiter #(
      .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .STATUS_REG(5'd30), .MD_EXC_CODE(32'd4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   ent_t        e_ent;
   ent_t        popped;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          head_since = 0;
   int          e_n;
   logic        e_we, e_stall, e_pop, e_acc, e_store, e_hit, e_ready;
   logic [4:0]  e_reg;
   logic [31:0] e_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: pending results are a plain queue; the head's wait time is measured
   // from the cycle it became head.
   task automatic model_eval();
      logic live;
      logic frc;
      e_n     = q.size();
      e_we    = 1'b0;
      e_reg   = '0;
      e_data  = '0;
      e_stall = 1'b0;
      e_pop   = 1'b0;
      e_hit   = 1'b0;
      e_ready = !reset && (e_n < DEPTH);
      live    = bus.pipe_we && (bus.pipe_reg != 5'd0);
      frc     = (e_n == DEPTH);
`ifdef ARB_STARVE_EN
      if (e_n > 0 && (cyc - head_since) >= STARVE_LIMIT) frc = 1'b1;
`endif
      if (!reset) begin
         if (e_n > 0 && frc) begin
            e_we = 1'b1; e_reg = q[0].r; e_data = q[0].d; e_pop = 1'b1; e_stall = live;
         end else if (live) begin
            e_we = 1'b1; e_reg = bus.pipe_reg; e_data = bus.pipe_data;
         end else if (e_n > 0) begin
            e_we = 1'b1; e_reg = q[0].r; e_data = q[0].d; e_pop = 1'b1;
         end
         foreach (q[i]) begin
            if ((bus.rs_a != 5'd0 && q[i].r == bus.rs_a) || (bus.rs_b != 5'd0 && q[i].r == bus.rs_b))
               e_hit = 1'b1;
         end
      end
      e_acc   = bus.md_valid && e_ready;
      e_store = e_acc && (bus.md_exception || bus.md_reg != 5'd0);
      e_ent.r = bus.md_exception ? 5'd30 : bus.md_reg;
      e_ent.d = bus.md_exception ? 32'd4 : bus.md_data;
   endtask

   task automatic settle();
      @(negedge clock);
      model_eval();
      chk("rf_we",      32'(bus.rf_we),      32'(e_we));
      chk("rf_reg",     32'(bus.rf_reg),     32'(e_reg));
      chk("rf_data",    bus.rf_data,         e_data);
      chk("stall",      32'(bus.stall),      32'(e_stall));
      chk("md_ready",   32'(bus.md_ready),   32'(e_ready));
      chk("pend_hit",   32'(bus.pend_hit),   32'(e_hit));
      chk("pend_count", 32'(bus.pend_count), reset ? 32'd0 : 32'(e_n));
   endtask

   task automatic advance();
      @(posedge clock);
      if (reset) begin
         q.delete();
      end else begin
         if (e_pop) popped = q.pop_front();
         if (e_store) q.push_back(e_ent);
      end
      if (q.size() > 0 && (e_pop || e_n == 0)) head_since = cyc + 1;
      cyc++;
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic drive(input logic pwe, input logic [4:0] preg, input logic [31:0] pdat,
                        input logic mv, input logic [4:0] mreg, input logic [31:0] mdat,
                        input logic mexc);
      bus.pipe_we      = pwe;
      bus.pipe_reg     = preg;
      bus.pipe_data    = pdat;
      bus.md_valid     = mv;
      bus.md_reg       = mreg;
      bus.md_data      = mdat;
      bus.md_exception = mexc;
   endtask

   initial begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      bus.rs_a = 5'd0;
      bus.rs_b = 5'd0;

      // Reset state, with requests present that must be ignored
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33, 1'b0);
      settle();
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_md_ready", 32'(bus.md_ready), 32'd0);
      advance();
      tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();

      // Idle drain
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0);
      settle(); chk("idle_cnt0", 32'(bus.pend_count), 32'd0); advance();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("idle_we", 32'(bus.rf_we), 32'd1);
      chk("idle_reg", 32'(bus.rf_reg), 32'd5);
      chk("idle_data", bus.rf_data, 32'h1234);
      chk("idle_stall", 32'(bus.stall), 32'd0);
      chk("idle_cnt1", 32'(bus.pend_count), 32'd1);
      advance();
      settle(); chk("idle_cnt2", 32'(bus.pend_count), 32'd0); advance();

      // Full FIFO forces a stolen slot
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33, 1'b0); tick();
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd4, 32'h44, 1'b0); tick();
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("full_ready", 32'(bus.md_ready), 32'd0);
      chk("full_stall", 32'(bus.stall), 32'd1);
      chk("full_reg", 32'(bus.rf_reg), 32'd3);
      advance();
      settle();
      chk("held_stall", 32'(bus.stall), 32'd0);
      chk("held_reg", 32'(bus.rf_reg), 32'd7);
      chk("held_data", bus.rf_data, 32'h77);
      advance();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle(); chk("full_tail_reg", 32'(bus.rf_reg), 32'd4); advance();

      // Exception redirect and $r0 result
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hdead, 1'b1); tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("exc_reg", 32'(bus.rf_reg), 32'd30);
      chk("exc_data", bus.rf_data, 32'd4);
      advance();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0); tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("r0_we", 32'(bus.rf_we), 32'd0);
      chk("r0_cnt", 32'(bus.pend_count), 32'd0);
      advance();

      // Hazard against a pending entry
      bus.rs_a = 5'd12;
      drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd12, 32'hc, 1'b0);
      settle(); chk("haz_incoming", 32'(bus.pend_hit), 32'd0); advance();
      drive(1'b1, 5'd7, 32'h71, 1'b0, 5'd0, 32'd0, 1'b0);
      settle(); chk("haz_hit", 32'(bus.pend_hit), 32'd1); advance();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle(); chk("haz_drain_reg", 32'(bus.rf_reg), 32'd12); advance();
      settle(); chk("haz_clear", 32'(bus.pend_hit), 32'd0); advance();
      bus.rs_a = 5'd0;

      // Push and pop together at one pending entry
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'ha, 1'b0); tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hb, 1'b0);
      settle(); chk("sim_a", 32'(bus.rf_reg), 32'd10); advance();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("sim_cnt", 32'(bus.pend_count), 32'd1);
      chk("sim_b", 32'(bus.rf_reg), 32'd11);
      advance();

      // Reset with two pending entries
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd20, 32'h20, 1'b0); tick();
      drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd21, 32'h21, 1'b0); tick();
      reset = 1'b1;
      drive(1'b1, 5'd7, 32'h3, 1'b1, 5'd22, 32'h22, 1'b0);
      settle();
      chk("mrst_we", 32'(bus.rf_we), 32'd0);
      chk("mrst_cnt", 32'(bus.pend_count), 32'd0);
      advance();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      chk("post_rst_we", 32'(bus.rf_we), 32'd0);
      chk("post_rst_cnt", 32'(bus.pend_count), 32'd0);
      advance();

`ifdef ARB_STARVE_EN
      // One entry starved by continuous writeback
      drive(1'b1, 5'd7, 32'h99, 1'b1, 5'd13, 32'hd, 1'b0); tick();
      drive(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
      for (int k = 0; k < STARVE_LIMIT; k++) begin
         settle(); chk("starve_wait", 32'(bus.stall), 32'd0); advance();
      end
      settle();
      chk("starve_stall", 32'(bus.stall), 32'd1);
      chk("starve_reg", 32'(bus.rf_reg), 32'd13);
      advance();
      settle(); chk("starve_resume", 32'(bus.rf_reg), 32'd7); advance();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
`endif

      // Randomized traffic; a stolen writeback is re-presented unchanged
      for (int k = 0; k < 500; k++) begin
         if (!e_stall) begin
            bus.pipe_we   = ($urandom_range(0, 9) < 7);
            bus.pipe_reg  = 5'($urandom_range(0, 7));
            bus.pipe_data = $urandom;
         end
         bus.md_valid     = ($urandom_range(0, 1) == 1);
         bus.md_reg       = 5'($urandom_range(0, 7));
         bus.md_data      = $urandom;
         bus.md_exception = ($urandom_range(0, 9) == 0);
         bus.rs_a         = 5'($urandom_range(0, 7));
         bus.rs_b         = 5'($urandom_range(0, 7));
         reset            = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
